uart_rx_fsm: RTL and testbench

Frame-sequencing controller for the UART receiver. It detects the start condition and counts oversampling edges and bits. It issues one-cycle enables to the deserializer, the data sampler and the start/parity/stop checkers, and it drops bad frames. It emits a one-cycle data_valid when the 8-bit word held by the deserializer is complete and error-free.

---
 rtl/uart_rx_fsm_pkg.sv | 21 ++
 rtl/uart_rx_fsm_if.sv | 32 +++
 rtl/uart_rx_edge_bit_counter.sv | 61 ++++++
 rtl/uart_rx_fsm.sv | 136 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fsm_pkg.sv
// Shared types and constants for the UART receiver frame sequencer.
package uart_rx_pkg;

    localparam int unsigned DATA_WIDTH_DEF     = 8;
    localparam int unsigned PRESCALE_WIDTH_DEF = 6;

    // Supported oversampling ratios
    localparam int unsigned PRESC_8  = 8;
    localparam int unsigned PRESC_16 = 16;
    localparam int unsigned PRESC_32 = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        OUTPUT = 3'd5
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Line/checker inputs and strobe outputs of the frame sequencer.
interface uart_rx_fsm_if #(
    parameter int unsigned PRESCALE_WIDTH = uart_rx_pkg::PRESCALE_WIDTH_DEF
);
    logic                      RX_IN;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      PAR_EN;
    logic                      strt_glitch;
    logic                      par_err;
    logic                      stp_err;
    logic                      data_samp_en;
    logic                      deser_en;
    logic                      strt_chk_en;
    logic                      par_chk_en;
    logic                      stp_chk_en;
    logic                      data_valid;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;

    // Receiver datapath side: drives line and checker results
    modport master (
        output RX_IN, prescale, PAR_EN, strt_glitch, par_err, stp_err,
        input  data_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
               data_valid, edge_cnt
    );

    // Sequencer side
    modport slave (
        input  RX_IN, prescale, PAR_EN, strt_glitch, par_err, stp_err,
        output data_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
               data_valid, edge_cnt
    );
endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and data-bit counter; edge wraps at presc_i-1.
module uart_rx_edge_bit_counter #(
    parameter int unsigned PRESCALE_WIDTH = 6,
    parameter int unsigned BIT_CNT_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      clr_i,
    input  logic                      en_i,
    input  logic                      bit_en_i,
    input  logic [PRESCALE_WIDTH-1:0] presc_i,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt_o,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt_o,
    output logic                      last_edge_o
);

    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
    logic                      last_edge;

    assign last_edge = (edge_cnt_q == (presc_i - PRESCALE_WIDTH'(1)));

    // Next counter values: start loads edge 1 (detection cycle already counted)
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (start_i) begin
            edge_cnt_d = PRESCALE_WIDTH'(1);
            bit_cnt_d  = '0;
        end else if (clr_i) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (en_i) begin
            if (last_edge) begin
                edge_cnt_d = '0;
                if (bit_en_i) begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_WIDTH'(1);
                end
            end else begin
                edge_cnt_d = edge_cnt_q + PRESCALE_WIDTH'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt_o  = edge_cnt_q;
    assign bit_cnt_o   = bit_cnt_q;
    assign last_edge_o = last_edge;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver frame sequencer: start detect, bit timing, check strobes.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
    input logic          clk,
    input logic          rst,
    uart_rx_fsm_if.slave bus
);

    localparam int unsigned BIT_CNT_WIDTH = $clog2(DATA_WIDTH + 1);

    rx_state_e                 state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
    logic                      last_edge;
    logic                      cnt_start, cnt_clr, cnt_en, bit_en;
    logic                      samp_en, deser, strt_chk, par_chk, stp_chk, dvalid;

    uart_rx_edge_bit_counter #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .start_i     (cnt_start),
        .clr_i       (cnt_clr),
        .en_i        (cnt_en),
        .bit_en_i    (bit_en),
        .presc_i     (presc_q),
        .edge_cnt_o  (edge_cnt),
        .bit_cnt_o   (bit_cnt),
        .last_edge_o (last_edge)
    );

    assign bit_en = (state_q == DATA);

    // Next state, counter control and strobe decode from registered state
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        cnt_start = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        samp_en   = 1'b0;
        deser     = 1'b0;
        strt_chk  = 1'b0;
        par_chk   = 1'b0;
        stp_chk   = 1'b0;
        dvalid    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.RX_IN) begin
                    state_d   = START;
                    cnt_start = 1'b1;
                    presc_d   = bus.prescale;
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            START: begin
                samp_en = 1'b1;
                cnt_en  = 1'b1;
                if (last_edge) begin
                    strt_chk = 1'b1;
                    state_d  = bus.strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                samp_en = 1'b1;
                cnt_en  = 1'b1;
                if (last_edge) begin
                    deser = 1'b1;
                    if (bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH - 1)) begin
                        state_d = bus.PAR_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                samp_en = 1'b1;
                cnt_en  = 1'b1;
                if (last_edge) begin
                    par_chk = 1'b1;
                    state_d = bus.par_err ? IDLE : STOP;
                end
            end
            STOP: begin
                samp_en = 1'b1;
                cnt_en  = 1'b1;
                if (last_edge) begin
                    stp_chk = 1'b1;
                    state_d = bus.stp_err ? IDLE : OUTPUT;
                end
            end
            OUTPUT: begin
                dvalid = 1'b1;
                // A low line here is the start of a back-to-back frame;
                // the prescale latched for the previous frame is kept.
                if (!bus.RX_IN) begin
                    state_d   = START;
                    cnt_start = 1'b1;
                end else begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // State and latched prescale registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            presc_q <= PRESCALE_WIDTH'(PRESC_8);
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
        end
    end

    assign bus.data_samp_en = samp_en;
    assign bus.deser_en     = deser;
    assign bus.strt_chk_en  = strt_chk;
    assign bus.par_chk_en   = par_chk;
    assign bus.stp_chk_en   = stp_chk;
    assign bus.data_valid   = dvalid;
    assign bus.edge_cnt     = edge_cnt;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed self-checking bench for the UART receiver frame sequencer.
module tb_uart_rx_fsm;
    import uart_rx_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_fsm_if #(.PRESCALE_WIDTH(6)) u_if ();

    uart_rx_fsm #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log: cumulative counts plus cycle stamps of deser_en / data_valid
    int n_deser = 0, n_dv = 0, n_strt = 0, n_par = 0, n_stp = 0;
    int deser_at [0:255];
    int dv_at    [0:255];
    always @(negedge clk) begin
        if (u_if.deser_en) begin
            deser_at[n_deser & 255] = cyc;
            n_deser = n_deser + 1;
        end
        if (u_if.data_valid) begin
            dv_at[n_dv & 255] = cyc;
            n_dv = n_dv + 1;
        end
        if (u_if.strt_chk_en) n_strt = n_strt + 1;
        if (u_if.par_chk_en)  n_par  = n_par + 1;
        if (u_if.stp_chk_en)  n_stp  = n_stp + 1;
    end

    int n_chk = 0, n_pass = 0;
    int det_cyc;
    int b_deser, b_dv, b_strt, b_par, b_stp;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle; this cycle is the detection cycle
    task automatic start_frame(input int presc, input logic par, input logic sg,
                               input logic pe, input logic se);
        u_if.prescale    = 6'(presc);
        u_if.PAR_EN      = par;
        u_if.strt_glitch = sg;
        u_if.par_err     = pe;
        u_if.stp_err     = se;
        b_deser = n_deser;
        b_dv    = n_dv;
        b_strt  = n_strt;
        b_par   = n_par;
        b_stp   = n_stp;
        u_if.RX_IN = 1'b0;
        det_cyc    = cyc;
        @(negedge clk);
        u_if.RX_IN = 1'b1;
    endtask

    function automatic int bad_gaps(input int base, input int presc);
        int bad = 0;
        for (int i = 1; i < 8; i++) begin
            if (deser_at[(base + i) & 255] - deser_at[(base + i - 1) & 255] != presc)
                bad++;
        end
        return bad;
    endfunction

    function automatic int outs();
        return int'({u_if.data_samp_en, u_if.deser_en, u_if.strt_chk_en,
                     u_if.par_chk_en, u_if.stp_chk_en, u_if.data_valid, u_if.edge_cnt});
    endfunction

    int found, cnt, b2b_dv, b2b_deser, dv1;

    initial begin
        rst              = 1'b0;
        u_if.RX_IN       = 1'b1;
        u_if.prescale    = 6'd8;
        u_if.PAR_EN      = 1'b0;
        u_if.strt_glitch = 1'b0;
        u_if.par_err     = 1'b0;
        u_if.stp_err     = 1'b0;

        // Reset state
        tick(3);
        chk("reset_outputs", outs(), 0);
        rst = 1'b1;
        tick(3);
        chk("idle_outputs", outs(), 0);

        // Prescale 8, no parity, clean frame
        start_frame(PRESC_8, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(100);
        chk("p8_deser_cnt", n_deser - b_deser, 8);
        chk("p8_first_deser", deser_at[b_deser & 255] - det_cyc, 15);
        chk("p8_deser_gaps", bad_gaps(b_deser, 8), 0);
        chk("p8_dv_cnt", n_dv - b_dv, 1);
        chk("p8_dv_latency", dv_at[b_dv & 255] - det_cyc, 80);
        chk("p8_strt_cnt", n_strt - b_strt, 1);
        chk("p8_par_cnt", n_par - b_par, 0);
        chk("p8_stp_cnt", n_stp - b_stp, 1);

        // Prescale 16 with parity, clean frame
        start_frame(PRESC_16, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(200);
        chk("p16_deser_cnt", n_deser - b_deser, 8);
        chk("p16_first_deser", deser_at[b_deser & 255] - det_cyc, 31);
        chk("p16_deser_gaps", bad_gaps(b_deser, 16), 0);
        chk("p16_par_cnt", n_par - b_par, 1);
        chk("p16_dv_cnt", n_dv - b_dv, 1);
        chk("p16_dv_latency", dv_at[b_dv & 255] - det_cyc, 176);

        // Prescale 8, start glitch
        start_frame(PRESC_8, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(6);
        chk("glitch_strt_chk", int'(u_if.strt_chk_en), 1);
        tick(1);
        chk("glitch_idle_samp", int'(u_if.data_samp_en), 0);
        chk("glitch_idle_edge", int'(u_if.edge_cnt), 0);
        tick(100);
        chk("glitch_deser_cnt", n_deser - b_deser, 0);
        chk("glitch_dv_cnt", n_dv - b_dv, 0);

        // Prescale 32, parity error drops frame, next frame clean
        start_frame(PRESC_32, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(400);
        chk("perr_par_cnt", n_par - b_par, 1);
        chk("perr_stp_cnt", n_stp - b_stp, 0);
        chk("perr_dv_cnt", n_dv - b_dv, 0);
        start_frame(PRESC_32, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(400);
        chk("p32_dv_cnt", n_dv - b_dv, 1);
        chk("p32_dv_latency", dv_at[b_dv & 255] - det_cyc, 352);
        chk("p32_deser_cnt", n_deser - b_deser, 8);

        // Stop error drops frame
        start_frame(PRESC_8, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(100);
        chk("serr_stp_cnt", n_stp - b_stp, 1);
        chk("serr_dv_cnt", n_dv - b_dv, 0);

        // Back-to-back frames at prescale 8
        b2b_dv    = n_dv;
        b2b_deser = n_deser;
        start_frame(PRESC_8, 1'b0, 1'b0, 1'b0, 1'b0);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (u_if.data_valid) begin
                found = 1;
                break;
            end
        end
        chk("b2b_first_dv_seen", found, 1);
        dv1 = cyc;
        u_if.RX_IN = 1'b0;
        tick(1);
        u_if.RX_IN = 1'b1;
        chk("b2b_restart_samp", int'(u_if.data_samp_en), 1);
        tick(100);
        chk("b2b_dv_cnt", n_dv - b2b_dv, 2);
        chk("b2b_dv_spacing", dv_at[(b2b_dv + 1) & 255] - dv1, 80);
        chk("b2b_deser_cnt", n_deser - b2b_deser, 16);

        // Reset during DATA bit 4
        start_frame(PRESC_8, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 4; i++) begin
            tick(1);
            if (u_if.deser_en) cnt++;
        end
        chk("rst_reached_bit4", cnt, 4);
        tick(3);
        #2 rst = 1'b0;
        #1 chk("rst_async_outputs", outs(), 0);
        @(negedge clk);
        rst = 1'b1;
        tick(20);
        chk("rst_no_dv", n_dv - b_dv, 0);
        start_frame(PRESC_8, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(100);
        chk("rst_after_deser_cnt", n_deser - b_deser, 8);
        chk("rst_after_dv_cnt", n_dv - b_dv, 1);
        chk("rst_after_dv_latency", dv_at[b_dv & 255] - det_cyc, 80);

        // Unsupported prescale must not lock up
        start_frame(0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(11 * 64 + 20);
        chk("bad_presc_idle", int'(u_if.data_samp_en), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
